// File: rtl/unified_mem_responder_pkg.sv
// ============================================================================
// unified_mem_responder_pkg : shared func3 codes and FSM state encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package unified_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/unified_mem_responder_lsu_align.sv
// ============================================================================
// lsu_align : byte-lane steering, load extension and alignment checking
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import unified_mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign byte_shift = rword >> {addr_lo, 3'b000};
  assign half_shift = rword >> {addr_lo[1], 4'b0000};
  assign rbyte      = byte_shift[7:0];
  assign rhalf      = half_shift[15:0];

  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    err        = 1'b0;
    case (func3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7]}}, rbyte};
      end
      F3_H: begin
        err        = addr_lo[0];
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15]}}, rhalf};
      end
      F3_W: begin
        err        = |addr_lo;
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      F3_BU: begin
        err        = we;
        rdata_ext  = {24'h0, rbyte};
      end
      F3_HU: begin
        err        = we | addr_lo[0];
        rdata_ext  = {16'h0, rhalf};
      end
      default: err = 1'b1;
    endcase
    // A faulted access must neither touch the array nor return data.
    if (err || !we) be = 4'b0000;
    if (err) rdata_ext = 32'h0;
  end

endmodule

`default_nettype wire

// File: rtl/unified_mem_responder.sv
// ============================================================================
// unified_mem_responder : shared fetch/data memory with fixed-priority arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module unified_mem_responder
  import unified_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_func3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                sel_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [2:0]          func3_q;
  logic                grant;
  logic                resp;
  logic                do_write;
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [31:0]         wdata_lane;
  logic [31:0]         rdata_ext;
  logic                align_err;
  logic [7:0]          mem [DEPTH];
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{d_addr[31:ADDR_W], if_addr[31:ADDR_W]};

  // Data port has fixed priority; nothing is granted outside IDLE.
  assign d_gnt  = (state == ST_IDLE) & ~rst & d_req;
  assign if_gnt = (state == ST_IDLE) & ~rst & if_req & ~d_req;
  assign grant  = d_gnt | if_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      sel_d   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      func3_q <= 3'b000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        sel_d   <= d_gnt;
        we_q    <= d_gnt & d_we;
        addr_q  <= d_gnt ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
        wdata_q <= d_wdata;
        func3_q <= d_func3;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          cnt_nxt   = LAT_M1;
          state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt   = cnt - 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rword = 32'h0;
    for (int b = 0; b < 4; b++) begin
      rword[8*b +: 8] = mem[{addr_q[ADDR_W-1:2], 2'(b)}];
    end
  end

  lsu_align u_lsu_align (
    .addr_lo    (addr_q[1:0]),
    .func3      (func3_q),
    .we         (we_q),
    .wdata      (wdata_q),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (align_err)
  );

  assign resp     = (state == ST_RESP);
  assign do_write = ~rst & resp & sel_d & we_q & ~align_err;

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[{addr_q[ADDR_W-1:2], 2'(b)}] <= wdata_lane[8*b +: 8];
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign d_rvalid  = resp & sel_d;
  assign if_rvalid = resp & ~sel_d;
  assign d_err     = d_rvalid & align_err;
  assign d_rdata   = (d_rvalid & ~we_q) ? rdata_ext : 32'h0;
  assign if_rdata  = if_rvalid ? rword : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_responder.sv
// ============================================================================
// tb_unified_mem_responder : directed table-driven bench for the responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_unified_mem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err, busy;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_func3;

  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_d_err, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata;
  logic        b_d_req, b_d_we;
  logic [31:0] b_d_addr, b_d_wdata;
  logic [2:0]  b_d_func3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  unified_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_func3(d_func3), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err), .busy(busy)
  );

  unified_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_func3(b_d_func3), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
    .d_rdata(b_d_rdata), .d_err(b_d_err), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge in IDLE.
  task automatic data_op(input vec_t v, input string tag,
                         output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_func3 = v.f3; d_wdata = v.wd;
    #1;
    while (!d_gnt && n < 20) begin @(negedge clk); #1; n++; end
    check({tag, " gnt"}, {31'h0, d_gnt}, 32'h1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    lat = 1;
    while (!d_rvalid && lat < 20) begin @(negedge clk); #1; lat++; end
    rd = d_rdata;
    er = d_err;
    @(negedge clk); #1;
    check({tag, " pulse/idle"}, {30'h0, d_rvalid, busy}, 32'h0);
  endtask

  task automatic data_op_l1(input vec_t v, input string tag,
                            output logic [31:0] rd, output int lat);
    int n = 0;
    b_d_req = 1'b1; b_d_we = v.we; b_d_addr = v.addr; b_d_func3 = v.f3; b_d_wdata = v.wd;
    #1;
    while (!b_d_gnt && n < 20) begin @(negedge clk); #1; n++; end
    check({tag, " gnt"}, {31'h0, b_d_gnt}, 32'h1);
    @(negedge clk);
    b_d_req = 1'b0;
    #1;
    lat = 1;
    while (!b_d_rvalid && lat < 20) begin @(negedge clk); #1; lat++; end
    rd = b_d_rdata;
    @(negedge clk); #1;
  endtask

  vec_t        vecs[22];
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;
  logic        seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h10,  3'b010, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h11,  3'b000, 32'h00000080, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h11,  3'b000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 32'h11,  3'b100, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 32'h10,  3'b001, 32'h0,        32'hFFFF80EF, 1'b0};
    vecs[6]  = '{1'b0, 32'h10,  3'b010, 32'h0,        32'hDEAD80EF, 1'b0};
    vecs[7]  = '{1'b0, 32'h12,  3'b101, 32'h0,        32'h0000DEAD, 1'b0};
    vecs[8]  = '{1'b0, 32'h12,  3'b001, 32'h0,        32'hFFFFDEAD, 1'b0};
    vecs[9]  = '{1'b0, 32'h12,  3'b010, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h13,  3'b001, 32'h00001234, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h10,  3'b010, 32'h0,        32'hDEAD80EF, 1'b0};
    vecs[12] = '{1'b0, 32'h10,  3'b011, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b1, 32'h104, 3'b010, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h04,  3'b010, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[15] = '{1'b1, 32'h14,  3'b010, 32'h11223344, 32'h0,        1'b0};
    vecs[16] = '{1'b1, 32'h16,  3'b001, 32'hAAAA5555, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 32'h14,  3'b010, 32'h0,        32'h55553344, 1'b0};
    vecs[18] = '{1'b0, 32'h16,  3'b001, 32'h0,        32'h00005555, 1'b0};
    vecs[19] = '{1'b1, 32'h14,  3'b100, 32'h000000FF, 32'h0,        1'b1};
    vecs[20] = '{1'b0, 32'h14,  3'b000, 32'h0,        32'h00000044, 1'b0};
    vecs[21] = '{1'b1, 32'h20,  3'b010, 32'h01010101, 32'h0,        1'b0};

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_func3 = 3'b000;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'h0; b_d_wdata = 32'h0; b_d_func3 = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset outputs", {26'h0, d_gnt, if_gnt, d_rvalid, if_rvalid, d_err, busy}, 32'h0);
    check("reset d_rdata", d_rdata, 32'h0);
    check("reset if_rdata", if_rdata, 32'h0);
    check("reset l1 busy", {31'h0, b_busy}, 32'h0);

    for (int i = 0; i < 22; i++) begin
      data_op(vecs[i], $sformatf("vec%0d", i), rd, er, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d latency", i), lat, 32'd2);
    end

    // Simultaneous requests: data wins, fetch follows right after data response.
    if_req = 1'b1; if_addr = 32'h13;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_func3 = 3'b010;
    #1;
    check("arb first grant", {30'h0, d_gnt, if_gnt}, 32'h2);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    n = 0;
    while (!d_rvalid && n < 20) begin @(negedge clk); #1; n++; end
    check("arb d_rdata", d_rdata, 32'hDEAD80EF);
    check("arb if_gnt before d_rvalid ends", {31'h0, if_gnt}, 32'h0);
    @(negedge clk); #1;
    check("arb if_gnt after d_rvalid", {31'h0, if_gnt}, 32'h1);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    n = 1;
    while (!if_rvalid && n < 20) begin @(negedge clk); #1; n++; end
    check("fetch latency", n, 32'd2);
    check("fetch rdata", if_rdata, 32'hDEAD80EF);
    @(negedge clk); #1;

    // LATENCY=1 instance.
    data_op_l1('{1'b1, 32'h08, 3'b010, 32'hA5A5_0F0F, 32'h0, 1'b0}, "l1 sw", rd, lat);
    check("l1 sw latency", lat, 32'd1);
    data_op_l1('{1'b0, 32'h08, 3'b010, 32'h0, 32'h0, 1'b0}, "l1 lw", rd, lat);
    check("l1 lw latency", lat, 32'd1);
    check("l1 lw rdata", rd, 32'hA5A50F0F);

    // Reset while in WAIT drops the pending store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_func3 = 3'b010; d_wdata = 32'hFFFFFFFF;
    #1;
    n = 0;
    while (!d_gnt && n < 20) begin @(negedge clk); #1; n++; end
    check("midrst gnt", {31'h0, d_gnt}, 32'h1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    check("midrst busy in wait", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (d_rvalid || busy) seen = 1'b1;
      @(negedge clk);
    end
    #1;
    check("midrst no rvalid", {31'h0, seen}, 32'h0);
    data_op('{1'b0, 32'h20, 3'b010, 32'h0, 32'h0, 1'b0}, "midrst lw", rd, er, lat);
    check("midrst array kept", rd, 32'h01010101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/unified_mem_responder.md
Name: unified_mem_responder

Overview:
Memory-side responder serving the core's two memory initiators: instruction fetch and data load/store. A single byte-addressed, little-endian storage array is shared by both ports. Requests pass through a fixed priority arbiter and complete after a configurable access latency. Sub-word loads and stores follow RV32 funct3 encodings.

Parameters:
ADDR_W, 8, byte-address bits used; array depth is 2^ADDR_W bytes.
LATENCY, 2, cycles from grant to response; legal range 1..15.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  reset; synchronous, active-high.
if_req  in  1  fetch request; held until granted.
if_addr  in  32  fetch byte address; bits [1:0] ignored.
if_gnt  out  1  fetch request accepted this cycle.
if_rvalid  out  1  one-cycle pulse; if_rdata valid.
if_rdata  out  32  fetched word.
d_req  in  1  data request; held until granted.
d_we  in  1  1 = store, 0 = load.
d_addr  in  32  data byte address.
d_wdata  in  32  store data; the low bytes are used for SB/SH.
d_func3  in  3  access size and sign (see Behaviour).
d_gnt  out  1  data request accepted this cycle.
d_rvalid  out  1  one-cycle pulse; load data or store acknowledge.
d_rdata  out  32  load result; 0 for stores and errors.
d_err  out  1  qualifies d_rvalid; 1 = misaligned access or illegal func3.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, counter=0, all outputs 0. Array contents are unaffected by reset.
- Reset mid-operation: the pending request is dropped; no write, no rvalid.
- FSM states: IDLE, WAIT, RESP.
- Grants are combinational and only possible in IDLE:
  - d_gnt = IDLE & d_req.
  - if_gnt = IDLE & if_req & ~d_req. Data has fixed priority over fetch.
- On grant: latch port select, address, we, wdata and func3. Load counter with LATENCY-1. Go to WAIT, or go directly to RESP if LATENCY==1.
- WAIT: decrement the counter each cycle. Go to RESP when it reaches 0.
- RESP:
  - Exactly one of if_rvalid or d_rvalid is high, LATENCY cycles after the grant cycle.
  - Stores commit to the array on the RESP clock edge. A following request therefore reads the new data.
  - Next state is IDLE. Throughput is one request per LATENCY+1 cycles.
- Addressing: index = addr[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo 2^ADDR_W.
- Fetch: always a full aligned word at {addr[ADDR_W-1:2],2'b00}. Never errors.
- Loads:
  - LB 000: sign-extend the byte.
  - LH 001: sign-extend the half.
  - LW 010: full word.
  - LBU 100: zero-extend the byte.
  - LHU 101: zero-extend the half.
- Stores:
  - SB 000: write d_wdata[7:0].
  - SH 001: write d_wdata[15:0].
  - SW 010: write all 32 bits.
  - Only the addressed bytes change.
- Errors:
  - Half access with addr[0]=1 → error.
  - Word access with addr[1:0]!=0 → error.
  - func3 011/110/111, and store func3 ≥ 100 → error.
  - On error: d_err=1 with d_rvalid, d_rdata=0, and the array is unchanged.
- Requests arriving while busy are not granted. The initiator holds req and address stable until gnt.

Decomposition:
- The shared defines file holds:
  - func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encodings (ST_IDLE, ST_WAIT, ST_RESP).
- One sub-module, lsu_align, is combinational. It takes addr[1:0], func3, we and wdata, plus the raw word for loads. It produces:
  - the 4-bit byte-write strobe,
  - the lane-shifted write data,
  - the extended load result,
  - the misalign/illegal error.
- The top holds the FSM, counter, arbiter and storage array.

Test Plan:
1. Reset then idle: hold rst=1 for 2 cycles and release → all outputs 0, busy=0. With rst high during WAIT → no rvalid afterwards.
2. SW then LW, LATENCY=2: SW addr 0x10, data 0xDEADBEEF → d_rvalid 2 cycles after d_gnt, d_err=0. LW 0x10 → d_rdata=0xDEADBEEF.
3. Sub-word access: after step 2, SB 0x11 with wdata 0x80 →
   - LB 0x11 → 0xFFFFFF80.
   - LBU 0x11 → 0x00000080.
   - LH 0x10 → 0xFFFF80EF.
   - LW 0x10 → 0xDEAD80EF.
4. Arbitration: if_req and d_req both high in IDLE → d_gnt first. if_gnt comes in the cycle after d_rvalid. if_addr 0x13 returns the word at 0x10.
5. Errors:
   - LW 0x12 → d_err=1, d_rdata=0.
   - SH 0x13 → d_err=1 and the word at 0x10 is unchanged.
   - func3=011 → d_err=1.
6. Wrap and latency: with ADDR_W=8, SW 0x104 then LW 0x04 → same data. With LATENCY=1, rvalid comes the cycle after gnt.
